// File: rtl/a21_keypad_pkg.sv
// a21_keypad_pkg: keypad matrix geometry and 16-bit key-vector helpers
package a21_keypad_pkg;
    localparam int N_COLS = 4;
    localparam int N_ROWS = 4;
    localparam int KEY_W  = 4;

    function automatic logic is_onehot16(input logic [15:0] v);
        return v != 16'h0 && (v & (v - 16'h1)) == 16'h0;
    endfunction

    function automatic logic [KEY_W-1:0] enc16(input logic [15:0] v);
        enc16 = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) enc16 = KEY_W'(i);
    endfunction
endpackage

// File: rtl/a21_prescaler.sv
// a21_prescaler: free-running divider, tick high for one clock every PRESCALE+1 clocks
module a21_prescaler #(
    parameter int PRESCALE = 10000
) (
    input  logic CLK,
    input  logic RSTn,
    output logic tick
);
    localparam int W = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;

    logic [W-1:0] count;

    assign tick = count == W'(PRESCALE);

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) count <= '0;
        else       count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/a21_keypad_scan.sv
// a21_keypad_scan: 4x4 keypad column scanner with whole-frame debounce and
// single-press events for the game logic.
module a21_keypad_scan
    import a21_keypad_pkg::*;
#(
    parameter int PRESCALE       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [N_ROWS-1:0] rowIn,
    output logic [N_COLS-1:0] colOut,
    output logic [KEY_W-1:0]  keyCode,
    output logic              keyValid,
    output logic              keyHeld
);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS - 1);

    logic        tick;
    logic [3:0]  row_meta, row_sync;
    logic [1:0]  col;
    logic [15:0] frame, full, cand, stable;
    logic [3:0]  cnt, cnt_inc;
    logic        match, accept;

    a21_prescaler #(.PRESCALE(PRESCALE)) u_pre (.CLK(CLK), .RSTn(RSTn), .tick(tick));

    assign colOut = ~(4'b0001 << col);

    // full is the frame as it will look after this tick's capture, so the
    // completing tick debounces a frame that includes column 3
    always_comb begin
        full = frame;
        full[{col, 2'b00} +: 4] = ~row_sync;
        cnt_inc = cnt == CNT_MAX ? cnt : cnt + 4'd1;
        match = full == cand;
        accept = match && cnt_inc == CNT_MAX && full != stable;
    end

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            row_meta <= '0;
            row_sync <= '0;
            col      <= '0;
            frame    <= '0;
            cand     <= '0;
            cnt      <= '0;
            stable   <= '0;
            keyCode  <= '0;
            keyValid <= 1'b0;
            keyHeld  <= 1'b0;
        end else begin
            row_meta <= rowIn;
            row_sync <= row_meta;
            keyValid <= 1'b0;
            if (tick) begin
                frame <= full;
                col   <= col + 2'd1;
                if (col == 2'd3) begin
                    cand <= full;
                    cnt  <= match ? cnt_inc : 4'd0;
                    if (accept) begin
                        stable  <= full;
                        keyHeld <= |full;
                        // only a lone key pressed from an all-released matrix is an event
                        if (stable == 16'h0 && is_onehot16(full)) begin
                            keyValid <= 1'b1;
                            keyCode  <= enc16(full);
                        end
                    end
                end
            end
        end
endmodule

// File: tb/tb_a21_keypad_scan.sv
// tb_a21_keypad_scan: frame-level keypad model driving the matrix, with table,
// hand-written and randomized press sequences checked against a debounce model.
module tb_a21_keypad_scan;
    localparam int PRESCALE = 3;
    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  rowIn;
    logic [3:0]  colOut;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyHeld;
    logic [15:0] pressed = 16'h0;

    int n_vec = 0;
    int n_fail = 0;
    int pulses = 0;

    logic [15:0] m_prev, m_stable;
    int          m_run;
    logic        m_valid, m_held;
    logic [3:0]  m_code;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic        exp_held;
    } vec_t;

    vec_t tbl[13];

    a21_keypad_scan #(.PRESCALE(PRESCALE), .DEBOUNCE_SCANS(D)) dut (
        .CLK(CLK), .RSTn(RSTn), .rowIn(rowIn), .colOut(colOut),
        .keyCode(keyCode), .keyValid(keyValid), .keyHeld(keyHeld)
    );

    always #5 CLK = ~CLK;

    // physical keypad: a pressed key shorts its row to the driven (low) column
    always_comb begin
        rowIn = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!colOut[c]) rowIn = rowIn & ~pressed[c*4 +: 4];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_stable = '0;
        m_run = 0;
        m_valid = 1'b0;
        m_held = 1'b0;
        m_code = '0;
    endtask

    // a key state is accepted once it has been seen on D consecutive frames
    task automatic model_frame(input logic [15:0] f);
        m_run = (m_run > 0 && f == m_prev) ? m_run + 1 : 1;
        m_prev = f;
        m_valid = 1'b0;
        if (m_run >= D && f != m_stable) begin
            if (m_stable == 16'h0 && $countones(f) == 1) begin
                m_valid = 1'b1;
                for (int b = 0; b < 16; b++)
                    if (f[b]) m_code = 4'(b);
            end
            m_stable = f;
        end
        m_held = m_stable != 16'h0;
    endtask

    task automatic run_frame(input logic [15:0] k);
        logic [3:0] ec;
        pressed = k;
        model_frame(k);
        for (int j = 1; j <= 16; j++) begin
            @(posedge CLK);
            #1;
            ec = ~(4'b0001 << ((j / 4) % 4));
            chk("colOut", {12'h0, colOut}, {12'h0, ec});
            if (j == 16) begin
                chk("keyValid", {15'h0, keyValid}, {15'h0, m_valid});
                chk("keyCode", {12'h0, keyCode}, {12'h0, m_code});
                chk("keyHeld", {15'h0, keyHeld}, {15'h0, m_held});
                pulses += int'(keyValid);
            end else begin
                chk("keyValid_idle", {15'h0, keyValid}, 16'h0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_colOut"}, {12'h0, colOut}, 16'h000E);
        chk({tag, "_keyValid"}, {15'h0, keyValid}, 16'h0);
        chk({tag, "_keyCode"}, {12'h0, keyCode}, 16'h0);
        chk({tag, "_keyHeld"}, {15'h0, keyHeld}, 16'h0);
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        model_reset();
    endtask

    initial begin
        int p0;
        logic [15:0] k;
        tbl[0]  = '{16'h0000,  2, 0, 4'h0, 1'b0};
        tbl[1]  = '{16'h0040,  6, 1, 4'h6, 1'b1};
        tbl[2]  = '{16'h0000,  6, 0, 4'h6, 1'b0};
        tbl[3]  = '{16'h8001,  6, 0, 4'h6, 1'b1};
        tbl[4]  = '{16'h0000,  6, 0, 4'h6, 1'b0};
        tbl[5]  = '{16'h8000,  6, 1, 4'hF, 1'b1};
        tbl[6]  = '{16'h0000,  6, 0, 4'hF, 1'b0};
        tbl[7]  = '{16'h0200, 20, 1, 4'h9, 1'b1};
        tbl[8]  = '{16'h0000,  3, 0, 4'h9, 1'b1};
        tbl[9]  = '{16'h0000,  1, 0, 4'h9, 1'b0};
        tbl[10] = '{16'h0008,  6, 1, 4'h3, 1'b1};
        tbl[11] = '{16'h0088,  6, 0, 4'h3, 1'b1};
        tbl[12] = '{16'h0000,  6, 0, 4'h3, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        release_reset();

        for (int i = 0; i < 13; i++) begin
            p0 = pulses;
            for (int f = 0; f < tbl[i].frames; f++) run_frame(tbl[i].keys);
            chk($sformatf("tbl%0d_pulses", i), 16'(pulses - p0), 16'(tbl[i].exp_pulses));
            chk($sformatf("tbl%0d_code", i), {12'h0, keyCode}, {12'h0, tbl[i].exp_code});
            chk($sformatf("tbl%0d_held", i), {15'h0, keyHeld}, {15'h0, tbl[i].exp_held});
        end

        p0 = pulses;
        for (int f = 0; f < 8; f++) run_frame(f % 2 == 0 ? 16'h0020 : 16'h0000);
        chk("bounce_pulses", 16'(pulses - p0), 16'h0);
        chk("bounce_held", {15'h0, keyHeld}, 16'h0);

        // reset lands mid-frame while a press of key A is two frames into debounce
        run_frame(16'h0400);
        run_frame(16'h0400);
        repeat (5) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (4) @(posedge CLK);
        #1;
        check_reset_outputs("midreset_hold");
        release_reset();
        p0 = pulses;
        for (int f = 0; f < 6; f++) run_frame(16'h0400);
        chk("redetect_pulses", 16'(pulses - p0), 16'h1);
        chk("redetect_code", {12'h0, keyCode}, 16'h000A);
        for (int f = 0; f < 5; f++) run_frame(16'h0000);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0:       k = 16'h0;
                3:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: k = 16'h1 << $urandom_range(0, 15);
            endcase
            for (int f = 0, n = $urandom_range(1, 6); f < n; f++) run_frame(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
